// File: rtl/trace_pkg.sv
// Shared types for the retire trace encoder: record kinds, serializer states and the
// queued record layout.
package trace_pkg;

  typedef enum logic [2:0] {
    TyNop   = 3'd0,
    TyReg   = 3'd1,
    TyLoad  = 3'd2,
    TyStore = 3'd3,
    TyHalt  = 3'd4
  } rec_type_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHdr  = 3'd1,
    StPc   = 3'd2,
    StW1   = 3'd3,
    StW2   = 3'd4
  } ser_state_e;

  // w1/w2 already hold the type-specific payload words chosen at capture time.
  typedef struct packed {
    rec_type_e   rtype;
    logic [3:0]  wreg;
    logic [15:0] pc;
    logic [15:0] w1;
    logic [15:0] w2;
  } record_t;

  localparam int unsigned RecWidth = $bits(record_t);

  function automatic logic [15:0] header_word(rec_type_e t, logic [3:0] r);
    return {t, r, 9'b0};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO holding captured trace records; the caller never pushes when
// full without a same-cycle pop and never pops when empty.
module trace_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             single
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [Aw-1:0]    wptr_q, rptr_q;
  logic [Aw:0]      count_q;

  assign full   = (count_q == (Aw+1)'(Depth));
  assign empty  = (count_q == '0);
  assign single = (count_q == (Aw+1)'(1));
  assign rdata  = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + Aw'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + Aw'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (Aw+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (Aw+1)'(1);
      end
    end
  end

endmodule

// File: rtl/trace_encoder.sv
// Captures retiring instructions as typed trace records, queues them and serializes each
// record as a burst of 16-bit words over a valid/ready stream.
module trace_encoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire_valid,
  input  logic [15:0] pc,
  input  logic        hlt,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic [15:0] tr_data,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic [15:0] inst_count,
  output logic        overflow,
  output logic        done
);

  import trace_pkg::*;

  ser_state_e  state_q, state_d;
  logic        halted_q, done_q, overflow_q;
  logic [15:0] count_q;

  record_t     rec_in, head;
  logic        retire, push, pop, last;
  logic        full, empty, single;
  logic [15:0] hdr;

  assign inst_count = count_q;
  assign overflow   = overflow_q;
  assign done       = done_q;

  always_comb begin
    rec_in    = '0;
    rec_in.pc = pc;
    if (reg_write && mem_read) begin
      rec_in.rtype = TyLoad;
      rec_in.wreg  = write_reg;
      rec_in.w1    = write_data;
      rec_in.w2    = mem_addr;
    end else if (reg_write) begin
      rec_in.rtype = TyReg;
      rec_in.wreg  = write_reg;
      rec_in.w1    = write_data;
    end else if (hlt) begin
      // The halt record reports the count including the halt itself.
      rec_in.rtype = TyHalt;
      rec_in.w1    = count_q + 16'd1;
    end else if (mem_write) begin
      rec_in.rtype = TyStore;
      rec_in.w1    = mem_addr;
      rec_in.w2    = mem_data;
    end else begin
      rec_in.rtype = TyNop;
    end
  end

  assign retire = retire_valid && !halted_q;
  assign push   = retire && (!full || pop);
  assign pop    = last;
  assign hdr    = header_word(head.rtype, head.wreg);

  trace_fifo #(
    .Width (RecWidth),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wdata  (rec_in),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .single (single)
  );

  // Idle presents the head header directly so a fresh record appears one cycle after capture.
  always_comb begin
    state_d  = state_q;
    tr_valid = 1'b0;
    tr_data  = '0;
    last     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !done_q) begin
          tr_valid = 1'b1;
          tr_data  = hdr;
          state_d  = tr_ready ? StPc : StHdr;
        end
      end
      StHdr: begin
        tr_valid = 1'b1;
        tr_data  = hdr;
        if (tr_ready) begin
          state_d = StPc;
        end
      end
      StPc: begin
        tr_valid = 1'b1;
        tr_data  = head.pc;
        if (tr_ready) begin
          if (head.rtype == TyNop) begin
            last = 1'b1;
          end else begin
            state_d = StW1;
          end
        end
      end
      StW1: begin
        tr_valid = 1'b1;
        tr_data  = head.w1;
        if (tr_ready) begin
          if (head.rtype == TyReg || head.rtype == TyHalt) begin
            last = 1'b1;
          end else begin
            state_d = StW2;
          end
        end
      end
      StW2: begin
        tr_valid = 1'b1;
        tr_data  = head.w2;
        if (tr_ready) begin
          last = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (last) begin
      state_d = (!single || push) ? StHdr : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        count_q <= count_q + 16'd1;
      end
      if (retire && rec_in.rtype == TyHalt) begin
        halted_q <= 1'b1;
      end
      if (retire && full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (last && head.rtype == TyHalt) begin
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/trace_encoder.md
TRACE_ENCODER -- requirements
Module: trace_encoder

Interface
REQ-001 SHALL have ports: clk in 1 (system clock, rising edge); rst_n in 1 (reset, asynchronous, active-low).
REQ-002 SHALL have retire inputs: retire_valid in 1 (one instruction retires this cycle); pc in 16 (PC of retiring instruction); hlt in 1; reg_write in 1; write_reg in 4 (destination register); write_data in 16 (register write value).
REQ-003 SHALL have memory retire inputs: mem_read in 1; mem_write in 1; mem_addr in 16; mem_data in 16 (store data).
REQ-004 SHALL have trace output ports: tr_data out 16; tr_valid out 1; tr_ready in 1 (sink accepts the word when tr_valid and tr_ready are both high at a rising edge).
REQ-005 SHALL have status outputs: inst_count out 16 (retires seen); overflow out 1 (sticky, a record was dropped); done out 1 (halt record fully sent).
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, number of buffered records (power of two, at least 2).

Function
REQ-007 SHALL classify each retire by priority: reg_write with mem_read gives LOAD(2); reg_write alone gives REG(1); else hlt gives HALT(4); else mem_write gives STORE(3); else NOP(0).
REQ-008 SHALL form the header word as {type[2:0], write_reg[3:0], 9'b0}, with write_reg zeroed for non-REG/LOAD types.
REQ-009 SHALL emit records in this order: NOP = hdr, pc; REG = hdr, pc, write_data; LOAD = hdr, pc, write_data, mem_addr; STORE = hdr, pc, mem_addr, mem_data; HALT = hdr, pc, inst_count (value including the halt).
REQ-010 SHALL capture all fields on the cycle retire_valid is high, so later input changes do not affect a queued record.
REQ-011 SHALL increment inst_count by 1, wrapping at 16'hFFFF to 0, on every retire_valid cycle before halt capture, including dropped retires.
REQ-012 SHALL push the record into the FIFO when not full; when full with a pop in the same cycle, SHALL accept the push.
REQ-013 SHALL drop the record when full with no pop, and set overflow, which stays high until reset.
REQ-014 SHALL ignore retire_valid, with no count change and no push, after a HALT record has been captured.
REQ-015 SHALL use a serializer FSM with states IDLE, HDR, PC, W1, W2: IDLE goes to HDR when the FIFO is non-empty; each state advances on handshake; NOP leaves after PC; REG/HALT leave after W1; LOAD/STORE leave after W2.
REQ-016 SHALL pop the FIFO entry on the handshake of the record's last word, then go to HDR if non-empty, else IDLE, with no idle bubble.
REQ-017 SHALL hold tr_valid high and tr_data stable while tr_ready is low, and SHALL never drop tr_valid before the handshake.
REQ-018 SHALL be able to push a retire into an empty FIFO and have the serializer present the header on the next cycle (latency 1).
REQ-019 SHALL raise done one cycle after the last HALT word handshake and hold it until reset, with tr_valid low afterwards.

Reset
REQ-020 SHALL apply these values while rst_n is low: tr_valid=0, tr_data=0, inst_count=0, overflow=0, done=0, FIFO empty, FSM=IDLE, halt-captured flag clear.
REQ-021 SHALL discard any in-flight record on reset mid-record, with no partial record resumed after reset.

Structure
REQ-022 SHALL take the type encodings (NOP/REG/LOAD/STORE/HALT) and FSM state encodings from a shared package trace_pkg.
REQ-023 SHALL implement the FIFO as one sub-module, trace_fifo (parameterised width/depth, push/pop/full/empty); serializer and classifier SHALL stay in trace_encoder.

Verification
REQ-024 SHALL verify a REG retire: pc=0x0004, write_reg=3, write_data=0x1234, tr_ready=1 -> words 0x2600, 0x0004, 0x1234 on consecutive cycles, with inst_count=1.
REQ-025 SHALL verify LOAD then STORE back-to-back: LOAD with r5, value 0xBEEF at address 0x0040, then STORE to address 0x0042 with data 0x00AA -> 0x4A00, pc, 0xBEEF, 0x0040, then 0x6000, pc, 0x0042, 0x00AA, with no gap.
REQ-026 SHALL verify backpressure: hold tr_ready=0 for 5 cycles mid-REG record -> tr_data frozen and tr_valid high; on release the record completes unchanged.
REQ-027 SHALL verify overflow: tr_ready=0 with 6 NOP retires at FIFO_DEPTH=4 -> 4 stored, overflow=1, inst_count=6; on release exactly 4 NOP records, 8 words.
REQ-028 SHALL verify halt: HALT at pc=0x0010 as the 3rd retire, followed by 2 more retires -> last words 0x8000, 0x0010, 0x0003; done=1 and inst_count stays 3.
REQ-029 SHALL verify reset mid-record: assert rst_n low after the header handshake -> all outputs at reset values; a new retire then emits a complete fresh record.
